sd_block_frontend: RTL and testbench

- CPU-facing register front end of the SD card controller peripheral.
- Decodes the command bytes that the program writes to the SD data port:
  - 0x01 followed by 4 address bytes opens a block.
  - 0x02 fetches the next byte.
- Requests a 512-byte block from the SD SPI engine and buffers it locally.
- Serves buffered bytes one at a time through the data port, with a status port that the program polls.

---
 rtl/sd_block_frontend.sv | 191 +++++++++++++++++++
 tb/tb_sd_block_frontend.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_frontend.sv
// sd_block_frontend
//   CPU-facing register front end of the SD card controller. The program
//   writes command bytes to the data port. 0x01 followed by four address
//   bytes (LSB first) opens a block. 0x02 fetches the next buffered byte.
//   A 512-byte block is requested from the SD SPI engine and buffered
//   locally. Bytes are then served one at a time through the data latch.
//
// Ports
//   clk, rst_n         system clock, synchronous active-low reset
//   bus_addr/wdata/we  CPU write side (single-cycle write strobe)
//   bus_rdata          combinational read data:
//                        data latch at DATA_ADDR, status at STAT_ADDR, 0 otherwise
//   blk_req/blk_addr   block read request to the SD engine
//   blk_ack            request accepted (1-cycle pulse)
//   byte_valid/data    block byte stream from the engine
//   blk_done/blk_err   end-of-block and failure pulses
//
// Status codes
//   0x01  ready (IDLE, ADDR)
//   0x00  busy  (REQ, FILL, FETCH)
//   0x02  error (ERR)
//
// Build option
//   SD_EARLY_READ_EN  accepts a 0x02 fetch during FILL. The fetch completes
//                     as soon as the requested byte has arrived.
module sd_block_frontend #(
  parameter logic [7:0] DATA_ADDR   = 8'h10,
  parameter logic [7:0] STAT_ADDR   = 8'h11,
  parameter int         BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_we,
  output logic [7:0]  bus_rdata,
  output logic        blk_req,
  output logic [31:0] blk_addr,
  input  logic        blk_ack,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        blk_done,
  input  logic        blk_err
);

  localparam int AW = $clog2(BLOCK_BYTES);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(BLOCK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_REQ, S_FILL, S_FETCH, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    addr_cnt;
  logic [7:0]    data_latch;
  logic [7:0]    status;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          filled;
  logic [7:0]    mem [BLOCK_BYTES];

  logic data_wr, cmd_open, cmd_fetch, fill_wr;

  assign data_wr   = bus_we && (bus_addr == DATA_ADDR);
  assign cmd_open  = data_wr && (bus_wdata == 8'h01);
  assign cmd_fetch = data_wr && (bus_wdata == 8'h02);

  // An error pulse wins over a simultaneous byte. Bytes beyond a full block are dropped.
  assign fill_wr = (state == S_FILL) && !blk_err && byte_valid && (wr_ptr != FULL);

`ifdef SD_EARLY_READ_EN
  logic early_pend, early_rdy, early_hit;
  assign early_hit = early_pend && ({1'b0, rd_ptr} < wr_ptr);
`endif

  // blk_req is gated by rst_n so that it drops immediately when reset is asserted.
  assign blk_req = rst_n && (state == S_REQ);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_open)       state_nxt = S_ADDR;
        else if (cmd_fetch) state_nxt = S_FETCH;
      end
      S_ADDR:  if (data_wr && addr_cnt == 2'd3) state_nxt = S_REQ;
      S_REQ:   if (blk_ack) state_nxt = S_FILL;
      S_FILL: begin
        if (blk_err)       state_nxt = S_ERR;
        else if (blk_done) state_nxt = (wr_ptr == FULL) ? S_IDLE : S_ERR;
      end
      S_FETCH: state_nxt = S_IDLE;
      S_ERR:   if (cmd_open) state_nxt = S_ADDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The buffer RAM is never cleared. Writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && fill_wr) mem[wr_ptr[AW-1:0]] <= byte_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt   <= '0;
      blk_addr   <= '0;
      data_latch <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      filled     <= 1'b0;
`ifdef SD_EARLY_READ_EN
      early_pend <= 1'b0;
      early_rdy  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_ERR: if (cmd_open) addr_cnt <= '0;
        S_ADDR: begin
          if (data_wr) begin
            blk_addr[{addr_cnt, 3'b000} +: 8] <= bus_wdata;
            addr_cnt <= addr_cnt + 2'd1;
          end
        end
        S_REQ: begin
          // A new fill invalidates the old buffer contents until it completes cleanly.
          if (blk_ack) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            filled <= 1'b0;
          end
        end
        S_FILL: begin
          if (fill_wr) wr_ptr <= wr_ptr + 1'b1;
          if (!blk_err && blk_done && wr_ptr == FULL) filled <= 1'b1;
`ifdef SD_EARLY_READ_EN
          if (early_hit) begin
            data_latch <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
            early_pend <= 1'b0;
            early_rdy  <= 1'b1;
          end else if (cmd_fetch && !early_pend) begin
            early_pend <= 1'b1;
            early_rdy  <= 1'b0;
          end
`endif
        end
        S_FETCH: begin
          // A fetch with no completed block returns 0x00 and leaves rd_ptr untouched.
          if (filled) begin
            data_latch <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
          end else begin
            data_latch <= '0;
          end
        end
        default: ;
      endcase
`ifdef SD_EARLY_READ_EN
      if (state != S_FILL) begin
        early_pend <= 1'b0;
        early_rdy  <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    status = 8'h00;
    case (state)
      S_IDLE, S_ADDR: status = 8'h01;
      S_ERR:          status = 8'h02;
`ifdef SD_EARLY_READ_EN
      S_FILL:         status = early_rdy ? 8'h01 : 8'h00;
`endif
      default:        status = 8'h00;
    endcase
  end

  always_comb begin
    bus_rdata = 8'h00;
    if (bus_addr == DATA_ADDR)      bus_rdata = data_latch;
    else if (bus_addr == STAT_ADDR) bus_rdata = status;
  end

endmodule

// File: tb/tb_sd_block_frontend.sv
// tb_sd_block_frontend
//   Randomized self-checking bench for sd_block_frontend. A reference model
//   holds the expected block contents, read index, data latch and
//   "block filled" flag. The bench predicts every data and status read from that model.
module tb_sd_block_frontend;

  localparam logic [7:0] DATA_ADDR = 8'h10;
  localparam logic [7:0] STAT_ADDR = 8'h11;
  localparam int         BB        = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bus_addr = STAT_ADDR;
  logic [7:0]  bus_wdata = 8'h00;
  logic        bus_we = 1'b0;
  logic [7:0]  bus_rdata;
  logic        blk_req;
  logic [31:0] blk_addr;
  logic        blk_ack = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        blk_done = 1'b0;
  logic        blk_err = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_buf [BB];
  int         ref_rd = 0;
  bit         ref_filled = 1'b0;
  logic [7:0] ref_latch = 8'h00;

  sd_block_frontend #(.DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR), .BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rdata(bus_rdata), .blk_req(blk_req), .blk_addr(blk_addr),
    .blk_ack(blk_ack), .byte_valid(byte_valid), .byte_data(byte_data),
    .blk_done(blk_done), .blk_err(blk_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
    bus_addr  = STAT_ADDR;
  endtask

  task automatic read_port(input logic [7:0] a, output logic [7:0] d);
    bus_addr = a;
    #1;
    d = bus_rdata;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] other;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (blk_req !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_blk_req_held: got %0b expected 0", blk_req);
    end
    rst_n = 1'b1;
    tick();
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h01) begin n_errors++; $display("[TB] FAIL reset_status: got %02h expected 01", d); end
    read_port(DATA_ADDR, d);
    n_checks++;
    if (d !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_data: got %02h expected 00", d); end
    n_checks++;
    if (blk_req !== 1'b0 || blk_addr !== 32'h0) begin
      n_errors++; $display("[TB] FAIL reset_req: got req=%0b addr=%08h expected 0/00000000", blk_req, blk_addr);
    end
    other = 8'($urandom_range(0, 255));
    if (other == DATA_ADDR || other == STAT_ADDR) other = 8'h33;
    read_port(other, d);
    n_checks++;
    if (d !== 8'h00) begin n_errors++; $display("[TB] FAIL unmapped_read: got %02h expected 00", d); end
    ref_rd = 0; ref_filled = 1'b0; ref_latch = 8'h00;
  endtask

  task automatic test_fetch(input int n, input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = ref_filled ? ref_buf[ref_rd] : 8'h00;
      if (ref_filled) ref_rd = (ref_rd + 1) % BB;
      ref_latch = exp;
      bus_write(DATA_ADDR, 8'h02);
      read_port(STAT_ADDR, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("[TB] FAIL %s_busy[%0d]: got %02h expected 00", tag, i, d); end
      tick();
      read_port(STAT_ADDR, d);
      n_checks++;
      if (d !== 8'h01) begin n_errors++; $display("[TB] FAIL %s_ready[%0d]: got %02h expected 01", tag, i, d); end
      read_port(DATA_ADDR, d);
      n_checks++;
      if (d !== exp) begin n_errors++; $display("[TB] FAIL %s_data[%0d]: got %02h expected %02h", tag, i, d, exp); end
      bus_addr = STAT_ADDR;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_bus_decode();
    logic [7:0] d;
    bus_write(STAT_ADDR, 8'h01);
    bus_write(STAT_ADDR, 8'h02);
    tick();
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h01) begin n_errors++; $display("[TB] FAIL stat_write_ignored: got %02h expected 01", d); end
    read_port(DATA_ADDR, d);
    n_checks++;
    if (d !== ref_latch) begin n_errors++; $display("[TB] FAIL stat_write_data: got %02h expected %02h", d, ref_latch); end
    test_fetch(2, "fetch_unfilled");
  endtask

  task automatic test_open_block(input logic [31:0] a, input string tag);
    logic [7:0] d;
    bus_write(DATA_ADDR, 8'h01);
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h01) begin n_errors++; $display("[TB] FAIL %s_open_status: got %02h expected 01", tag, d); end
    for (int b = 0; b < 4; b++) begin
      bus_write(DATA_ADDR, a[8*b +: 8]);
      read_port(STAT_ADDR, d);
      n_checks++;
      if (d !== ((b < 3) ? 8'h01 : 8'h00)) begin
        n_errors++; $display("[TB] FAIL %s_addr_status[%0d]: got %02h expected %02h", tag, b, d, (b < 3) ? 8'h01 : 8'h00);
      end
    end
    n_checks++;
    if (blk_req !== 1'b1 || blk_addr !== a) begin
      n_errors++; $display("[TB] FAIL %s_request: got req=%0b addr=%08h expected 1/%08h", tag, blk_req, blk_addr, a);
    end
  endtask

  // Delivers bytes [first, first+n) of the block. first == 0 also performs the ack handshake.
  task automatic test_fill(input int first, input int n, input bit pattern, input int extra, input string tag);
    logic [7:0] d;
    if (first == 0) begin
      repeat ($urandom_range(0, 3)) tick();
      n_checks++;
      if (blk_req !== 1'b1) begin n_errors++; $display("[TB] FAIL %s_req_hold: got %0b expected 1", tag, blk_req); end
      blk_ack = 1'b1;
      tick();
      blk_ack = 1'b0;
      read_port(STAT_ADDR, d);
      n_checks++;
      if (blk_req !== 1'b0 || d !== 8'h00) begin
        n_errors++; $display("[TB] FAIL %s_ack: got req=%0b status=%02h expected 0/00", tag, blk_req, d);
      end
      ref_filled = 1'b0;
      ref_rd = 0;
    end
    for (int i = first; i < first + n + extra; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      byte_data  = pattern ? 8'(i & 8'hFF) : 8'($urandom_range(0, 255));
      byte_valid = 1'b1;
      if (i < BB) ref_buf[i] = byte_data;
      tick();
      byte_valid = 1'b0;
    end
  endtask

  task automatic test_done(input logic [7:0] exp_status, input string tag);
    logic [7:0] d;
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== exp_status) begin n_errors++; $display("[TB] FAIL %s_done_status: got %02h expected %02h", tag, d, exp_status); end
    if (exp_status == 8'h01) ref_filled = 1'b1;
  endtask

  task automatic test_error();
    logic [7:0] d;
    test_open_block($urandom, "short");
    test_fill(0, 300, 1'b0, 0, "short");
    test_done(8'h02, "short");
    n_checks++;
    if (blk_req !== 1'b0) begin n_errors++; $display("[TB] FAIL err_blk_req: got %0b expected 0", blk_req); end
    bus_write(DATA_ADDR, 8'h02);
    repeat (2) tick();
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h02) begin n_errors++; $display("[TB] FAIL err_fetch_ignored: got %02h expected 02", d); end
    read_port(DATA_ADDR, d);
    n_checks++;
    if (d !== ref_latch) begin n_errors++; $display("[TB] FAIL err_data_held: got %02h expected %02h", d, ref_latch); end
    // Error pulse collides with done and a byte: error wins.
    test_open_block($urandom, "restart");
    test_fill(0, 50, 1'b0, 0, "errpulse");
    blk_err = 1'b1; blk_done = 1'b1; byte_valid = 1'b1; byte_data = 8'h5A;
    tick();
    blk_err = 1'b0; blk_done = 1'b0; byte_valid = 1'b0;
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h02) begin n_errors++; $display("[TB] FAIL err_priority: got %02h expected 02", d); end
    // Clean recovery with surplus bytes that must be dropped.
    test_open_block($urandom, "recover");
    test_fill(0, BB, 1'b0, 3, "recover");
    test_done(8'h01, "recover");
    test_fetch(5, "recover_fetch");
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d;
    test_open_block($urandom, "rstreq");
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (blk_req !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_req_immediate: got %0b expected 0", blk_req); end
    tick();
    rst_n = 1'b1;
    tick();
    test_open_block($urandom, "rstfill");
    test_fill(0, 100, 1'b0, 0, "rstfill");
    rst_n = 1'b0; byte_valid = 1'b1; byte_data = 8'($urandom_range(0, 255));
    tick();
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h01 || blk_req !== 1'b0) begin
      n_errors++; $display("[TB] FAIL rst_mid_fill: got status=%02h req=%0b expected 01/0", d, blk_req);
    end
    tick();
    rst_n = 1'b1; byte_valid = 1'b0;
    tick();
    read_port(DATA_ADDR, d);
    n_checks++;
    if (d !== 8'h00 || blk_addr !== 32'h0) begin
      n_errors++; $display("[TB] FAIL rst_regs: got data=%02h addr=%08h expected 00/00000000", d, blk_addr);
    end
    bus_addr = STAT_ADDR;
    ref_filled = 1'b0; ref_rd = 0; ref_latch = 8'h00;
    test_fetch(1, "rst_fetch");
  endtask

  task automatic test_early_read();
    logic [7:0] d;
    test_open_block($urandom, "early");
    test_fill(0, 0, 1'b0, 0, "early");
    ref_buf[0] = 8'hAA; ref_buf[1] = 8'hBB; ref_buf[2] = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      byte_data = ref_buf[i]; byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
    end
    bus_write(DATA_ADDR, 8'h02);
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h00) begin n_errors++; $display("[TB] FAIL early_busy: got %02h expected 00", d); end
    tick();
`ifdef SD_EARLY_READ_EN
    ref_latch = 8'hAA;
    ref_rd = 1;
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h01) begin n_errors++; $display("[TB] FAIL early_ready: got %02h expected 01", d); end
`else
    read_port(STAT_ADDR, d);
    n_checks++;
    if (d !== 8'h00) begin n_errors++; $display("[TB] FAIL early_ignored: got %02h expected 00", d); end
`endif
    read_port(DATA_ADDR, d);
    n_checks++;
    if (d !== ref_latch) begin n_errors++; $display("[TB] FAIL early_data: got %02h expected %02h", d, ref_latch); end
    bus_addr = STAT_ADDR;
    test_fill(3, BB - 3, 1'b0, 0, "early");
    test_done(8'h01, "early");
    test_fetch(3, "early_fetch");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      test_open_block($urandom, "b2b");
      test_fill(0, BB, 1'b0, 0, "b2b");
      test_done(8'h01, "b2b");
      test_fetch($urandom_range(3, 10), "b2b_fetch");
    end
  endtask

  initial begin
    test_reset();
    test_bus_decode();
    test_open_block(32'h12345678, "plan");
    test_fill(0, BB, 1'b1, 0, "plan");
    test_done(8'h01, "plan");
    test_fetch(BB + 1, "wrap");
    test_error();
    test_reset_mid_fill();
    test_early_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
